// File: rtl/isa_pkg.sv
// Shared ISA definitions for the instruction fetch sequencer: word layout, op encoding,
// halt word and FSM state encoding (StPause exists only when SINGLE_STEP_EN is defined).
package isa_pkg;

    localparam int unsigned INSTR_W = 13;

    localparam int unsigned OP_BIT  = 0;
    localparam int unsigned IMM_LSB = 1;
    localparam int unsigned IMM_W   = 8;
    localparam int unsigned SRC_LSB = 9;
    localparam int unsigned SRC_W   = 2;
    localparam int unsigned DST_LSB = 11;
    localparam int unsigned DST_W   = 2;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_MUL = 1'b0;

    localparam logic [INSTR_W-1:0] HALT_INSTR = 13'h1FFF;

    // Wide enough for the largest supported ROM wait of 15 cycles.
    localparam int unsigned WAIT_W = 4;

    typedef struct packed {
        logic [DST_W-1:0] dst;
        logic [SRC_W-1:0] src;
        logic [IMM_W-1:0] imm;
        logic             op;
    } instr_t;

    localparam int unsigned INSTR_BITS = $bits(instr_t);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StIssue = 3'd2,
        StWrite = 3'd3,
`ifdef SINGLE_STEP_EN
        StHalt  = 3'd4,
        StPause = 3'd5
`else
        StHalt  = 3'd4
`endif
    } fsm_state_e;

    function automatic logic is_add(input instr_t instr);
        return instr.op == OP_ADD;
    endfunction

endpackage

// File: rtl/fetch_wait_ctr.sv
// ROM access wait counter: loads the configured wait, counts down once per decrement request
// and flags the decrement on which the count reaches zero.
module fetch_wait_ctr
    import isa_pkg::*;
#(
    parameter int unsigned LOAD_VAL = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam logic [WAIT_W-1:0] CntOne  = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] CntLoad = LOAD_VAL[WAIT_W-1:0];

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CntLoad;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntOne;
        end
    end

    // A count already at zero also reports zero so a fetch can never stall forever.
    assign zero_o = dec_i && (cnt_q <= CntOne);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch/issue sequencer: walks a ROM from address 0, issues decoded fields to the
// datapath with a valid/ready handshake and stops on the halt word. Option: SINGLE_STEP_EN.
module instr_fetch_seq #(
    parameter int unsigned               ADDR_W     = 8,
    parameter int unsigned               INSTR_W    = isa_pkg::INSTR_W,
    parameter int unsigned               ROM_WAIT   = 2,
    parameter logic [INSTR_W-1:0]        HALT_INSTR = isa_pkg::HALT_INSTR
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               rom_oe_n,
    input  logic [INSTR_W-1:0] rom_data,
    output logic               op_add,
    output logic [7:0]         imm,
    output logic [1:0]         src_sel,
    output logic [1:0]         dst_sel,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic               wr_strobe,
    output logic               busy,
`ifdef SINGLE_STEP_EN
    input  logic               step_mode,
    input  logic               step,
`endif
    output logic               halted
);

    import isa_pkg::*;

    fsm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    instr_t            instr_q, instr_d;

    logic wait_load;
    logic wait_dec;
    logic wait_zero;
    logic fetch_is_halt;

    fetch_wait_ctr #(
        .LOAD_VAL (ROM_WAIT)
    ) u_wait_ctr (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .load_i (wait_load),
        .dec_i  (wait_dec),
        .zero_o (wait_zero)
    );

    assign fetch_is_halt = (rom_data == HALT_INSTR);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        wait_load = 1'b0;
        wait_dec  = 1'b0;
        case (state_q)
            StIdle, StHalt: begin
                if (start) begin
                    pc_d      = '0;
                    wait_load = 1'b1;
                    state_d   = StFetch;
                end
            end
            StFetch: begin
                wait_dec = 1'b1;
                if (wait_zero) begin
                    if (fetch_is_halt) begin
                        state_d = StHalt;
                    end else begin
                        instr_d = instr_t'(rom_data[INSTR_BITS-1:0]);
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (issue_ready) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // pc rolls over naturally at 2^ADDR_W-1.
                pc_d = pc_q + 1'b1;
`ifdef SINGLE_STEP_EN
                if (step_mode) begin
                    state_d = StPause;
                end else begin
                    wait_load = 1'b1;
                    state_d   = StFetch;
                end
`else
                wait_load = 1'b1;
                state_d   = StFetch;
`endif
            end
`ifdef SINGLE_STEP_EN
            StPause: begin
                if (step) begin
                    wait_load = 1'b1;
                    state_d   = StFetch;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Outputs decode straight from state so an asynchronous reset clears them at once.
    assign rom_addr    = pc_q;
    assign rom_oe_n    = (state_q != StFetch);
    assign issue_valid = (state_q == StIssue);
    assign wr_strobe   = (state_q == StWrite);
    assign halted      = (state_q == StHalt);
    assign busy        = (state_q != StIdle) && (state_q != StHalt);

    assign op_add  = is_add(instr_q);
    assign imm     = instr_q.imm;
    assign src_sel = instr_q.src;
    assign dst_sel = instr_q.dst;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Self-checking bench for instr_fetch_seq: ROM model with access latency, directed timing
// steps, and randomized ROM/handshake runs checked against a transaction-level model.
module tb_instr_fetch_seq;

    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned INSTR_W  = 13;
    localparam int unsigned ROM_WAIT = 2;
    localparam int unsigned ROM_N    = 1 << ADDR_W;
    localparam logic [INSTR_W-1:0] HALT = 13'h1FFF;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [ADDR_W-1:0]  rom_addr;
    logic               rom_oe_n;
    logic [INSTR_W-1:0] rom_data;
    logic               op_add;
    logic [7:0]         imm;
    logic [1:0]         src_sel;
    logic [1:0]         dst_sel;
    logic               issue_valid;
    logic               issue_ready;
    logic               wr_strobe;
    logic               busy;
    logic               halted;
`ifdef SINGLE_STEP_EN
    logic               step_mode;
    logic               step;
`endif

    int vectors    = 0;
    int miscompares = 0;

    logic [INSTR_W-1:0] rom [ROM_N];
    logic [ADDR_W-1:0]  last_addr = '0;
    int                 addr_age  = 0;

    instr_fetch_seq #(
        .ADDR_W     (ADDR_W),
        .INSTR_W    (INSTR_W),
        .ROM_WAIT   (ROM_WAIT),
        .HALT_INSTR (HALT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_oe_n    (rom_oe_n),
        .rom_data    (rom_data),
        .op_add      (op_add),
        .imm         (imm),
        .src_sel     (src_sel),
        .dst_sel     (dst_sel),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .wr_strobe   (wr_strobe),
        .busy        (busy),
`ifdef SINGLE_STEP_EN
        .step_mode   (step_mode),
        .step        (step),
`endif
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // ROM: data is only correct once the address has been stable ROM_WAIT cycles with oe_n low.
    always @(negedge clk) begin
        if (rom_addr !== last_addr) addr_age = 1;
        else if (addr_age < 1000) addr_age = addr_age + 1;
        last_addr = rom_addr;
        if (!rom_oe_n && addr_age >= int'(ROM_WAIT)) rom_data = rom[rom_addr];
        else rom_data = rom[rom_addr] ^ 13'h0555;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected fields come straight from the documented word layout.
    task automatic chk_fields(input string tag, input logic [INSTR_W-1:0] w);
        chk({tag, "_op"},  op_add,  32'(w[0]));
        chk({tag, "_imm"}, imm,     32'(w[8:1]));
        chk({tag, "_src"}, src_sel, 32'(w[10:9]));
        chk({tag, "_dst"}, dst_sel, 32'(w[12:11]));
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, issue_valid, 0);
        chk({tag, "_wr"},    wr_strobe,   0);
        chk({tag, "_busy"},  busy,        0);
        chk({tag, "_halt"},  halted,      0);
        chk({tag, "_oen"},   rom_oe_n,    1);
    endtask

    function automatic logic sel_sig(input int which);
        return (which == 0) ? issue_valid : wr_strobe;
    endfunction

    task automatic wait_sig(input int which, input int budget, input string tag);
        int n = 0;
        while (sel_sig(which) !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, sel_sig(which), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [INSTR_W-1:0] rand_word();
        return INSTR_W'($urandom_range(0, 32'h1FFE));
    endfunction

    initial begin
        int e;
        int nwr;
        int cyc;
        int last;
        logic pend;

        rst_n       = 1'b0;
        start       = 1'b0;
        issue_ready = 1'b0;
`ifdef SINGLE_STEP_EN
        step_mode   = 1'b0;
        step        = 1'b0;
`endif
        for (int i = 0; i < int'(ROM_N); i++) rom[i] = rand_word();
        rom[0] = 13'h0803;
        rom[2] = HALT;

        repeat (3) tick();
        chk_quiet("reset");
        chk("reset_addr", rom_addr, 0);
        chk_fields("reset_fields", 13'h0000);
        rst_n = 1'b1;
        tick();

        // First instruction timing: start is cycle 0.
        issue_ready = 1'b1;
        pulse_start();
        chk("c1_busy", busy, 1);
        chk("c1_oen", rom_oe_n, 0);
        chk("c1_valid", issue_valid, 0);
        tick();
        chk("c2_valid", issue_valid, 0);
        tick();
        chk("c3_valid", issue_valid, 1);
        chk_fields("c3", rom[0]);
        tick();
        chk("c4_wr", wr_strobe, 1);
        chk("c4_valid", issue_valid, 0);
        tick();
        chk("c5_addr", rom_addr, 1);
        chk("c5_wr", wr_strobe, 0);

        // Back-pressure: fields and pc hold while issue_ready is low.
        issue_ready = 1'b0;
        tick();
        tick();
        chk("bp_valid", issue_valid, 1);
        chk_fields("bp", rom[1]);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp_hold_valid", issue_valid, 1);
            chk("bp_hold_wr", wr_strobe, 0);
            chk("bp_hold_pc", rom_addr, 1);
            chk_fields("bp_hold", rom[1]);
        end
        issue_ready = 1'b1;
        tick();
        chk("bp_wr", wr_strobe, 1);

        // Halt word at address 2.
        tick();
        chk("halt_fetch_addr", rom_addr, 2);
        tick();
        chk("halt_pre", halted, 0);
        tick();
        chk("halt_flag", halted, 1);
        chk("halt_busy", busy, 0);
        chk("halt_valid", issue_valid, 0);
        chk_fields("halt_hold", rom[1]);
        repeat (3) tick();
        chk("halt_stays", halted, 1);
        pulse_start();
        chk("restart_addr", rom_addr, 0);
        chk("restart_busy", busy, 1);
        chk("restart_halt", halted, 0);

        // Reset during ISSUE.
        issue_ready = 1'b0;
        wait_sig(0, 10, "rst_issue");
        #2 rst_n = 1'b0;
        #1 chk_quiet("rst_issue_now");
        chk("rst_issue_addr", rom_addr, 0);
        chk_fields("rst_issue_fields", 13'h0000);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_quiet("rst_issue_idle");
        end

        // Reset during WRITE.
        issue_ready = 1'b1;
        pulse_start();
        wait_sig(1, 10, "rst_write");
        #2 rst_n = 1'b0;
        #1 chk_quiet("rst_write_now");
        chk("rst_write_addr", rom_addr, 0);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_quiet("rst_write_idle");
        end

        // Full-rate run over every address, wrapping 255 -> 0.
        rom[2] = rand_word();
        issue_ready = 1'b1;
        pulse_start();
        e = 0; nwr = 0; cyc = 1; last = 0;
        while (nwr < 260 && cyc < 260 * 8) begin
            if (wr_strobe) begin
                chk("wrap_pc", rom_addr, e);
                chk_fields("wrap", rom[e]);
                chk("wrap_interval", cyc - last, ROM_WAIT + 2);
                last = cyc;
                e = (e + 1) % int'(ROM_N);
                nwr++;
            end
            if (nwr < 260) begin
                tick();
                cyc++;
            end
        end
        chk("wrap_count", nwr, 260);

        // Random handshake: every accepted issue must produce one write, in ROM order.
        pend = 1'b0;
        nwr  = 0;
        cyc  = 0;
        while (nwr < 150 && cyc < 150 * 16) begin
            tick();
            cyc++;
            chk("rnd_wr", wr_strobe, pend);
            if (wr_strobe) begin
                chk("rnd_wr_pc", rom_addr, e);
                e = (e + 1) % int'(ROM_N);
                nwr++;
            end
            if (issue_valid) begin
                chk("rnd_pc", rom_addr, e);
                chk_fields("rnd", rom[e]);
            end
            issue_ready = ($urandom_range(0, 3) != 0);
            pend = issue_valid && issue_ready;
        end
        chk("rnd_count", nwr, 150);

`ifdef SINGLE_STEP_EN
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        step_mode   = 1'b1;
        issue_ready = 1'b1;
        pulse_start();
        wait_sig(1, 10, "ss_first");
        tick();
        for (int k = 0; k < 6; k++) begin
            start = (k == 2);
            tick();
            chk("ss_pause_wr", wr_strobe, 0);
            chk("ss_pause_busy", busy, 1);
            chk("ss_pause_pc", rom_addr, 1);
        end
        start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            nwr = 0;
            step = 1'b1;
            tick();
            step = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (wr_strobe) begin
                    chk("ss_step_pc", rom_addr, s + 1);
                    nwr++;
                end
                tick();
            end
            chk("ss_one_wr", nwr, 1);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_seq.md
INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

Interface
REQ-001 Parameter ADDR_W, default 8: ROM address / program-counter width.
REQ-002 Parameter INSTR_W, default 13: instruction word width.
REQ-003 Parameter ROM_WAIT, default 2, range 1..15: clock cycles from address change to valid rom_data.
REQ-004 Parameter HALT_INSTR, default 13'h1FFF: instruction word that stops the sequencer.
REQ-005 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n (clk first, rst_n second).
REQ-006 clk  in  1  rising-edge system clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 start  in  1  one-cycle pulse that begins execution at address 0.
REQ-009 rom_addr  out  ADDR_W  program counter driven to the ROM address port.
REQ-010 rom_oe_n  out  1  ROM output enable, active low.
REQ-011 rom_data  in  INSTR_W  ROM instruction word.
REQ-012 op_add  out  1  instruction bit 0: 1 = add, 0 = multiply.
REQ-013 imm  out  8  instruction bits 8:1, the switch-operand byte.
REQ-014 src_sel  out  2  instruction bits 10:9, input register bus-enable select.
REQ-015 dst_sel  out  2  instruction bits 12:11, output register select.
REQ-016 issue_valid  out  1  decoded instruction fields are valid.
REQ-017 issue_ready  in  1  datapath accepts the instruction.
REQ-018 wr_strobe  out  1  one-cycle clock-enable pulse to the register chosen by dst_sel.
REQ-019 busy  out  1  high in every state except IDLE and HALT.
REQ-020 halted  out  1  high in HALT.

Function
REQ-021 The FSM SHALL have the states IDLE, FETCH, ISSUE, WRITE and HALT, plus PAUSE when the macro in REQ-036 is defined.
REQ-022 IDLE: when start=1, pc SHALL be set to 0, the wait counter SHALL be loaded with ROM_WAIT, and the FSM SHALL move to FETCH.
REQ-023 FETCH: the wait counter SHALL decrement once per cycle; on the cycle it reaches 0, rom_data SHALL be sampled.
REQ-024 FETCH exit: if the sampled word equals HALT_INSTR, the FSM SHALL go to HALT; otherwise the word SHALL be latched into the instruction register and the FSM SHALL go to ISSUE.
REQ-025 ISSUE: issue_valid SHALL stay high and the instruction fields SHALL stay stable until issue_ready=1; the FSM SHALL then go to WRITE.
REQ-026 WRITE: wr_strobe SHALL be high for exactly one cycle, issue_valid SHALL be low, pc SHALL increment, and the FSM SHALL go to FETCH with the wait counter reloaded.
REQ-027 pc SHALL wrap from 2^ADDR_W-1 to 0 and execution SHALL continue.
REQ-028 Latency from start to the first issue_valid SHALL be ROM_WAIT+1 cycles.
REQ-029 Each instruction SHALL take ROM_WAIT+2 cycles when issue_ready is held high.
REQ-030 start SHALL be ignored in FETCH, ISSUE and WRITE.
REQ-031 start in HALT SHALL restart execution exactly as from IDLE.
REQ-032 rom_oe_n SHALL be 0 in FETCH and 1 otherwise.
REQ-033 op_add, imm, src_sel and dst_sel SHALL be driven from the instruction register and SHALL hold their value outside ISSUE.

Reset
REQ-034 When rst_n=0, in any state and mid-instruction, the FSM SHALL go to IDLE and pc, the instruction register, the wait counter, issue_valid, wr_strobe, busy and halted SHALL all be 0, with rom_oe_n=1.
REQ-035 A wr_strobe already in progress SHALL be cut off immediately by reset, and no stale issue SHALL follow reset release.

Configuration
REQ-036 When SINGLE_STEP_EN is defined, the block SHALL add inputs step_mode and step; with step_mode=1, WRITE SHALL go to PAUSE, and PAUSE SHALL go to FETCH on a step pulse.
REQ-037 Without SINGLE_STEP_EN, step_mode, step and PAUSE SHALL NOT exist, and WRITE SHALL always go to FETCH.

Structure
REQ-038 A shared package isa_pkg SHALL hold INSTR_W, the field bit positions, the op encoding (ADD=1, MUL=0), HALT_INSTR and the FSM state enum.
REQ-039 The ROM wait counter SHALL be a separate sub-module, fetch_wait_ctr, with load, decrement and zero-flag ports.

Verification
REQ-040 Reset then start, with ROM_WAIT=2, ROM[0]=13'h0803 and issue_ready=1 -> issue_valid at cycle 3; op_add=1, imm=8'h01, src_sel=0, dst_sel=1; wr_strobe at cycle 4; rom_addr=1 at cycle 5.
REQ-041 Hold issue_ready=0 for 5 cycles -> issue_valid and all fields stable, no wr_strobe, pc unchanged.
REQ-042 ROM[2]=13'h1FFF -> halted=1 after two wr_strobes; a later start -> rom_addr=0, busy=1.
REQ-043 All 256 ROM words non-halt -> rom_addr wraps from 255 to 0 with no stall.
REQ-044 rst_n pulsed low during ISSUE and during WRITE -> all outputs 0 immediately, IDLE after release, start required to resume.
REQ-045 SINGLE_STEP_EN defined, step_mode=1 -> exactly one wr_strobe per step pulse; start is ignored while in PAUSE.
